// File: rtl/apb_pkg.sv
// Shared types and constants for the APB slave memory block.
package apb_pkg;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} apb_state_e;

  localparam int APB_ADDR_W = 8;
  localparam int APB_DATA_W = 8;

  localparam logic [APB_DATA_W-1:0] RDERR_DATA = 8'hFF;

endpackage

// File: rtl/apb_slv_regfile.sv
// DEPTH x 8 register array: one synchronous write port, one combinational
// read port, asynchronous active-low clear of every entry.
module apb_slv_regfile
  import apb_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                  pclk,
  input  logic                  prst,
  input  logic                  we,
  input  logic [IDX_W-1:0]      waddr,
  input  logic [APB_DATA_W-1:0] wdata,
  input  logic [IDX_W-1:0]      raddr,
  output logic [APB_DATA_W-1:0] rdata
);

  logic [APB_DATA_W-1:0] mem [DEPTH];

  // NOTE: the array sits in the reset branch on purpose: every entry must read
  // back 8'h00 after reset, which rules out a RAM macro without a clear.
  always_ff @(posedge pclk or negedge prst) begin
    if (!prst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/apb_slave_mem.sv
// APB slave with a small register memory and WAIT_CYCLES wait states.
// Define APB_SLV_PSLVERR_EN to add the pslverr port and 8'hFF error reads.
module apb_slave_mem
  import apb_pkg::*;
#(
  parameter int DEPTH       = 16,
  parameter int WAIT_CYCLES = 0
) (
  input  logic                  pclk,
  input  logic                  prst,
  input  logic                  psel,
  input  logic                  pen,
  input  logic                  pwrite,
  input  logic [APB_ADDR_W-1:0] paddr,
  input  logic [APB_DATA_W-1:0] pwdata,
  output logic [APB_DATA_W-1:0] prdata,
  output logic                  pready
`ifdef APB_SLV_PSLVERR_EN
  ,
  output logic                  pslverr
`endif
);

  localparam int         IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [2:0] WAIT_INIT = 3'(WAIT_CYCLES);
`ifdef APB_SLV_PSLVERR_EN
  localparam logic [APB_DATA_W-1:0] OOR_DATA = RDERR_DATA;
`else
  localparam logic [APB_DATA_W-1:0] OOR_DATA = '0;
`endif

  apb_state_e            state;
  logic [APB_ADDR_W-1:0] addr_q;
  logic                  write_q;
  logic [APB_DATA_W-1:0] wdata_q;
  logic [2:0]            wcnt;
  logic                  err;

  logic                  access;
  logic                  setup_hit;
  logic                  complete;
  logic                  ready_set;
  logic                  cur_write;
  logic                  in_range;
  logic                  we;
  logic [APB_ADDR_W-1:0] cur_addr;
  logic [APB_DATA_W-1:0] rdata;
  logic [APB_DATA_W-1:0] rd_value;

  // On the SETUP edge the live bus is decoded; in ACCESS only latched copies are.
  // NOTE: every output of this block is assigned on every path, so no latch
  // can be inferred even though several terms depend on state.
  always_comb begin
    access    = (state == ACCESS);
    setup_hit = !access && psel && !pen;
    complete  = access && psel && pen && pready;
    cur_addr  = access ? addr_q : paddr;
    cur_write = access ? write_q : pwrite;
    in_range  = (32'(cur_addr) < DEPTH);
    ready_set = (setup_hit && (WAIT_CYCLES == 0)) ||
                (access && psel && pen && !pready && (wcnt == 3'd1));
    rd_value  = in_range ? rdata : OOR_DATA;
    we        = complete && write_q && in_range;
  end

  apb_slv_regfile #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_regfile (
    .pclk  (pclk),
    .prst  (prst),
    .we    (we),
    .waddr (addr_q[IDX_W-1:0]),
    .wdata (wdata_q),
    .raddr (cur_addr[IDX_W-1:0]),
    .rdata (rdata)
  );

  // The SETUP phase is taken on the edge that closes the bus SETUP cycle, so
  // the state register never dwells in SETUP; that keeps a registered pready
  // able to land in the first ACCESS cycle when WAIT_CYCLES is 0.
  // NOTE: state is written with <= only, so every read of state, pready or wcnt
  // in this block sees the value from before the edge.
  always_ff @(posedge pclk or negedge prst) begin
    if (!prst) begin
      state   <= IDLE;
      addr_q  <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
      wcnt    <= '0;
      prdata  <= '0;
      pready  <= 1'b0;
      err     <= 1'b0;
    end else begin
      case (state)
        ACCESS: begin
          if (!psel || !pen) begin
            state  <= IDLE;
            pready <= 1'b0;
            err    <= 1'b0;
            wcnt   <= '0;
          end else if (pready) begin
            state  <= IDLE;
            pready <= 1'b0;
            err    <= 1'b0;
          end else if (wcnt != '0) begin
            wcnt <= wcnt - 3'd1;
          end
        end
        default: begin
          if (setup_hit) begin
            addr_q  <= paddr;
            write_q <= pwrite;
            wdata_q <= pwdata;
            wcnt    <= WAIT_INIT;
            state   <= ACCESS;
          end else begin
            state <= IDLE;
          end
        end
      endcase

      if (ready_set) begin
        pready <= 1'b1;
        err    <= !in_range;
        if (!cur_write) prdata <= rd_value;
      end
    end
  end

`ifdef APB_SLV_PSLVERR_EN
  assign pslverr = err;
`else
  logic unused_err;
  assign unused_err = err;
`endif

endmodule
